// File: rtl/id_operand_stage.sv
// id_operand_stage: one-register RV32I operand-decode stage with a valid/ready handshake.
// Optional feature macro ID_ILLEGAL_TRAP_EN adds an illegal-opcode flag and a saturating counter.
module id_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  Si,
    output logic [11:0] imm12_I,
    output logic [11:0] imm12_S,
    output logic [19:0] imm20,
    output logic [31:0] PC,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] SI_PB    = 3'b000;
    localparam logic [2:0] SI_IMM_I = 3'b001;
    localparam logic [2:0] SI_IMM_S = 3'b010;
    localparam logic [2:0] SI_IMM20 = 3'b011;
    localparam logic [2:0] SI_PC    = 3'b100;

    // Second-operand select; unknown opcodes fall back to the register operand.
    function automatic logic [2:0] si_decode(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_BRANCH:   si_decode = SI_PB;
            OPC_OPIMM, OPC_LOAD:  si_decode = SI_IMM_I;
            OPC_STORE:            si_decode = SI_IMM_S;
            OPC_LUI, OPC_AUIPC:   si_decode = SI_IMM20;
            OPC_JAL, OPC_JALR:    si_decode = SI_PC;
            default:              si_decode = SI_PB;
        endcase
    endfunction

    logic        accept_s;
    logic        out_valid_q, out_valid_d;
    logic [2:0]  si_q, si_d;
    logic [11:0] imm_i_q, imm_i_d;
    logic [11:0] imm_s_q, imm_s_d;
    logic [19:0] imm20_q, imm20_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;

    // Handshake: flush blocks acceptance even when the stage has room.
    always_comb begin
        in_ready = (!out_valid_q || out_ready) && !flush;
        accept_s = in_valid && in_ready;
    end

    // Next-state for the bundle; fields only load on acceptance so a stall holds them.
    always_comb begin
        out_valid_d = out_valid_q;
        si_d        = si_q;
        imm_i_d     = imm_i_q;
        imm_s_d     = imm_s_q;
        imm20_d     = imm20_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            si_d        = si_decode(instr[6:0]);
            imm_i_d     = instr[31:20];
            imm_s_d     = {instr[31:25], instr[11:7]};
            imm20_d     = instr[31:12];
            pc_d        = pc_in;
            rs1_d       = instr[19:15];
            rs2_d       = instr[24:20];
            rd_d        = instr[11:7];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Bundle register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            si_q        <= 3'd0;
            imm_i_q     <= 12'd0;
            imm_s_q     <= 12'd0;
            imm20_q     <= 20'd0;
            pc_q        <= 32'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
        end else begin
            out_valid_q <= out_valid_d;
            si_q        <= si_d;
            imm_i_q     <= imm_i_d;
            imm_s_q     <= imm_s_d;
            imm20_q     <= imm20_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Si        = si_q;
    assign imm12_I   = imm_i_q;
    assign imm12_S   = imm_s_q;
    assign imm20     = imm20_q;
    assign PC        = pc_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;

`ifdef ID_ILLEGAL_TRAP_EN
    // True for the nine opcodes the operand decode understands.
    function automatic logic opcode_known(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_BRANCH, OPC_OPIMM, OPC_LOAD, OPC_STORE,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opcode_known = 1'b1;
            default:                               opcode_known = 1'b0;
        endcase
    endfunction

    logic       illegal_q, illegal_d;
    logic [7:0] ill_cnt_q, ill_cnt_d;

    // Flag tracks the accepted instruction; the count saturates at 255.
    always_comb begin
        illegal_d = illegal_q;
        ill_cnt_d = ill_cnt_q;
        if (accept_s) begin
            illegal_d = !opcode_known(instr[6:0]);
            if (!opcode_known(instr[6:0]) && (ill_cnt_q != 8'hFF)) begin
                ill_cnt_d = ill_cnt_q + 8'd1;
            end else begin
                ill_cnt_d = ill_cnt_q;
            end
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Trap state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            ill_cnt_q <= 8'd0;
        end else begin
            illegal_q <= illegal_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign illegal       = illegal_q;
    assign illegal_count = ill_cnt_q;
`else
    assign illegal       = 1'b0;
    assign illegal_count = 8'd0;
`endif

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports `clk` and `reset`.
REQ-002 The ports SHALL be as follows; every width is a bit count:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the fetch side presents an instruction.
- `in_ready`  out  1  the stage accepts an instruction this cycle.
- `instr`  in  32  the raw RV32I instruction.
- `pc_in`  in  32  the address of `instr`.
- `flush`  in  1  discard the held and the incoming instruction.
- `out_valid`  out  1  the decoded operand bundle is valid.
- `out_ready`  in  1  the execute side consumes the bundle.
- `Si`  out  3  the second-operand select for the operand handler.
- `imm12_I`  out  12  the I-type immediate field.
- `imm12_S`  out  12  the S-type immediate field.
- `imm20`  out  20  the U-type immediate field.
- `PC`  out  32  the registered copy of `pc_in`.
- `rs1`, `rs2`, `rd`  out  5 each  the register specifiers.
- `illegal`  out  1  the held instruction has an unknown opcode (macro-gated).
- `illegal_count`  out  8  a saturating count of illegal instructions (macro-gated).

Function
REQ-003 The stage SHALL be a single register stage; the latency from acceptance to `out_valid` SHALL be 1 cycle.
REQ-004 `in_ready` SHALL equal (!`out_valid` || `out_ready`) && !`flush`, combinationally.
REQ-005 An acceptance SHALL occur when `in_valid` && `in_ready`; on acceptance, all output fields SHALL load from the decode of `instr` and `pc_in`, and `out_valid` SHALL be 1 in the next cycle.
REQ-006 When `out_valid` && `out_ready` && no acceptance, `out_valid` SHALL be 0 in the next cycle.
REQ-007 When `out_valid` && !`out_ready`, every output SHALL hold its value unchanged.
REQ-008 Consume and accept in the same cycle SHALL replace the bundle with no bubble (full throughput).
REQ-009 On `flush`, `out_valid` SHALL be 0 in the next cycle and no instruction SHALL be accepted that cycle.
- `flush` SHALL win over `in_valid` and over `out_ready`.
- The data fields MAY retain stale values.
REQ-010 The field extraction SHALL be, irrespective of opcode:
- `imm12_I` = `instr`[31:20].
- `imm12_S` = {`instr`[31:25], `instr`[11:7]}.
- `imm20` = `instr`[31:12].
- `rs1` = [19:15], `rs2` = [24:20], `rd` = [11:7].
REQ-011 `Si`, keyed on opcode `instr`[6:0], SHALL decode as follows:
- 0110011 (R-type) and 1100011 (branch) → 000 (PB).
- 0010011 (OP-IMM) and 0000011 (load) → 001 (imm12_I).
- 0100011 (store) → 010 (imm12_S).
- 0110111 (LUI) and 0010111 (AUIPC) → 011 (imm20).
- 1101111 (JAL) and 1100111 (JALR) → 100 (PC).
- Any other opcode → 000.
REQ-012 The codes 101–111 SHALL never be produced.

Reset
REQ-013 With `reset` high at a clock edge, the following SHALL be 0 in the next cycle: `out_valid`, `Si`, all immediates, `PC`, `rs1`, `rs2`, `rd`, `illegal`, and `illegal_count`.
REQ-014 Reset SHALL override `flush`, acceptance and hold; an in-flight bundle SHALL be discarded.
REQ-015 `in_ready` SHALL be 1 in the first cycle after reset deasserts, given `flush` is 0.

Configuration
REQ-016 With macro `ID_ILLEGAL_TRAP_EN` defined:
- `illegal` SHALL register 1 for any opcode outside REQ-011 on acceptance.
- `illegal_count` SHALL increment on each such acceptance and saturate at 255.
- Flushed instructions SHALL not count.
REQ-017 Without `ID_ILLEGAL_TRAP_EN`, `illegal` and `illegal_count` SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Store: `instr` = 0x00F12623, `pc_in` = 0x1000, `in_valid` = 1, `out_ready` = 1 → next cycle `out_valid` = 1, `Si` = 010, `imm12_S` = 0x00C, `rs2` = 15, `PC` = 0x1000.
- Stall: `out_ready` = 0 for 3 cycles after a LUI 0xABCDE0B7 → `in_ready` = 0, and `Si` = 011, `imm20` = 0xABCDE held all 3 cycles.
- Back-to-back: ADDI, then JAL, then ADD, with `out_ready` = 1 → `out_valid` high 3 consecutive cycles with `Si` = 001, then 100, then 000.
- Flush with `in_valid` = 1 while a bundle is held → `out_valid` = 0 next cycle and the incoming instruction is dropped.
- Reset asserted mid-stall → all outputs 0 next cycle, then `in_ready` = 1.
- With the macro: 260 accepted opcodes 0x7F → `illegal` = 1 and `illegal_count` = 255 (saturated).
